// File: rtl/pulse_updown_counter_pkg.sv
// Shared types and elaboration-time helpers for the pulse up/down counter.
package pulse_counter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HOLD_INC = 3'd1,
    ST_RPT_INC  = 3'd2,
    ST_HOLD_DEC = 3'd3,
    ST_RPT_DEC  = 3'd4
  } rpt_state_e;

  // 64-bit product: MHz clocks times hundreds of ms overflow 32 bits.
  function automatic int unsigned ms_to_cycles(input longint unsigned clk_hz,
                                               input longint unsigned ms);
    return 32'((clk_hz * ms) / 64'd1000);
  endfunction

  function automatic int unsigned timer_width(input int unsigned hold_cyc,
                                              input int unsigned rpt_cyc);
    int unsigned span;
    span = (hold_cyc > rpt_cyc) ? hold_cyc : rpt_cyc;
    return (span < 2) ? 1 : $clog2(span);
  endfunction

endpackage

// File: rtl/pulse_updown_counter_edge_detect_rise.sv
// One-cycle rising-edge detector on a level already synchronous to clk.
module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev_d, prev_q;

  always_comb prev_d = d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/pulse_updown_counter.sv
// Modulo up/down counter stepped by debounced button edges, with step/wrap strobes.
// Auto-repeat while a button is held is compiled in with PULSE_COUNTER_AUTOREPEAT_EN.
module pulse_updown_counter
  import pulse_counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MAX_VALUE   = 9,
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_in,
  input  logic             dec_in,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             step_up,
  output logic             step_dn,
  output logic             ovf,
  output logic             unf
);

  localparam int unsigned HOLD_CYC = ms_to_cycles(64'(CLK_FREQ_HZ), 64'(HOLD_MS));
  localparam int unsigned RPT_CYC  = ms_to_cycles(64'(CLK_FREQ_HZ), 64'(REPEAT_MS));
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  if (MAX_VALUE < 0 || longint'(MAX_VALUE) >= (longint'(1) << WIDTH)) begin : g_bad_max
    $error("MAX_VALUE must satisfy 0 <= MAX_VALUE < 2**WIDTH");
  end
  if (HOLD_CYC == 0 || RPT_CYC == 0) begin : g_bad_timing
    $error("HOLD_MS and REPEAT_MS must each span at least one clk cycle");
  end

  logic rise_inc, rise_dec;

  edge_detect_rise u_inc_edge (.clk(clk), .rst(rst), .d(inc_in), .rise(rise_inc));
  edge_detect_rise u_dec_edge (.clk(clk), .rst(rst), .d(dec_in), .rise(rise_dec));

  logic [WIDTH-1:0] count_d, count_q;
  logic             step_up_d, step_up_q, step_dn_d, step_dn_q;
  logic             ovf_d, ovf_q, unf_d, unf_q;
  logic             do_inc, do_dec;

`ifdef PULSE_COUNTER_AUTOREPEAT_EN
  localparam int unsigned TIMER_W = timer_width(HOLD_CYC, RPT_CYC);
  localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_CYC - 1);
  localparam logic [TIMER_W-1:0] RPT_LAST  = TIMER_W'(RPT_CYC - 1);
  localparam logic [TIMER_W-1:0] T_ONE     = TIMER_W'(1);

  rpt_state_e         state_d, state_q;
  logic [TIMER_W-1:0] timer_d, timer_q;
`endif

  always_comb begin
    do_inc = 1'b0;
    do_dec = 1'b0;
`ifdef PULSE_COUNTER_AUTOREPEAT_EN
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (rise_inc && !rise_dec) begin
          do_inc  = 1'b1;
          state_d = ST_HOLD_INC;
        end else if (rise_dec && !rise_inc) begin
          do_dec  = 1'b1;
          state_d = ST_HOLD_DEC;
        end
      end
      // Hold and repeat phases share one timer; only the terminal count differs.
      ST_HOLD_INC, ST_RPT_INC: begin
        if (!inc_in || dec_in) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q == ((state_q == ST_HOLD_INC) ? HOLD_LAST : RPT_LAST)) begin
          do_inc  = 1'b1;
          timer_d = '0;
          state_d = ST_RPT_INC;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      ST_HOLD_DEC, ST_RPT_DEC: begin
        if (!dec_in || inc_in) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q == ((state_q == ST_HOLD_DEC) ? HOLD_LAST : RPT_LAST)) begin
          do_dec  = 1'b1;
          timer_d = '0;
          state_d = ST_RPT_DEC;
        end else begin
          timer_d = timer_q + T_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
    if (clr) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end
`else
    do_inc = rise_inc & ~rise_dec;
    do_dec = rise_dec & ~rise_inc;
`endif

    count_d   = count_q;
    step_up_d = 1'b0;
    step_dn_d = 1'b0;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (do_inc) begin
      step_up_d = 1'b1;
      if (count_q == MAX_V) begin
        count_d = '0;
        ovf_d   = 1'b1;
      end else begin
        count_d = count_q + ONE;
      end
    end else if (do_dec) begin
      step_dn_d = 1'b1;
      if (count_q == '0) begin
        count_d = MAX_V;
        unf_d   = 1'b1;
      end else begin
        count_d = count_q - ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
`ifdef PULSE_COUNTER_AUTOREPEAT_EN
      state_q   <= ST_IDLE;
      timer_q   <= '0;
`endif
    end else begin
      count_q   <= count_d;
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
`ifdef PULSE_COUNTER_AUTOREPEAT_EN
      state_q   <= state_d;
      timer_q   <= timer_d;
`endif
    end
  end

  assign count   = count_q;
  assign step_up = step_up_q;
  assign step_dn = step_dn_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;

endmodule

// File: doc/pulse_updown_counter.md
Name: pulse_updown_counter

Overview:
- Downstream consumer of two debounce_fsm instances in the pulse-adder design: one on the increment button, one on the decrement button.
- Detects rising edges on the debounced levels and steps a modulo up/down counter; the counter value drives the display stage.
- Emits one-cycle step and wrap strobes.
- Optional auto-repeat while a button is held.

Parameters:
- WIDTH, 4, counter width in bits.
- MAX_VALUE, 9, highest count before wrap; must satisfy MAX_VALUE < 2**WIDTH (elaboration error otherwise).
- CLK_FREQ_HZ, 12000000, clk frequency; used only by auto-repeat.
- HOLD_MS, 500, hold time before auto-repeat starts.
- REPEAT_MS, 100, auto-repeat period.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- inc_in  in  1  debounced increment level, synchronous to clk.
- dec_in  in  1  debounced decrement level, synchronous to clk.
- clr  in  1  synchronous clear, active-high.
- count  out  WIDTH  current counter value.
- step_up  out  1  one-cycle strobe, registered with each increment.
- step_dn  out  1  one-cycle strobe, registered with each decrement.
- ovf  out  1  one-cycle strobe when an increment wraps MAX_VALUE->0.
- unf  out  1  one-cycle strobe when a decrement wraps 0->MAX_VALUE.

Behaviour:
- Reset values:
  - count=0, step_up=step_dn=ovf=unf=0.
  - Edge-detect history registers are 0.
  - FSM state is IDLE.
- Edge detect:
  - rise_inc = inc_in & ~inc_prev; rise_dec likewise.
  - History registers update every cycle.
- Latency: count and strobes change on the clk edge after the cycle in which the input is first sampled high (1 cycle).
- Priority order:
  1. clr: count<=0, all strobes 0, FSM->IDLE, edges ignored that cycle.
  2. Both steps requested in the same cycle: no change, no strobes.
  3. Single inc step, or single dec step.
- Increment: count==MAX_VALUE -> count<=0 with ovf=1; else count+1. step_up=1 in both cases.
- Decrement: count==0 -> count<=MAX_VALUE with unf=1; else count-1. step_dn=1 in both cases.
- Strobes are 0 in every cycle without a step.
- Holding a level high without the macro produces exactly one step.
- Arithmetic is unsigned WIDTH-bit; no intermediate value exceeds MAX_VALUE.

Optional Feature:
- Macro: PULSE_COUNTER_AUTOREPEAT_EN.
- With the macro: a repeat FSM is compiled in.
  - States: IDLE, HOLD_INC, RPT_INC, HOLD_DEC, RPT_DEC.
  - Timer constants: HOLD_CYC = CLK_FREQ_HZ*HOLD_MS/1000 and RPT_CYC = CLK_FREQ_HZ*REPEAT_MS/1000.
  - IDLE: a single rise_inc produces the normal step and enters HOLD_INC with the timer cleared. HOLD_DEC is symmetric.
  - HOLD_x: the timer counts while the input stays high. At HOLD_CYC-1 the FSM generates one step, clears the timer and moves to RPT_x.
  - RPT_x: generates one step every RPT_CYC cycles.
  - Return to IDLE from any HOLD/RPT state: the held input drops, the other input goes high, or clr is asserted. No step is generated in that cycle except a normal single edge from IDLE rules on the following cycle.
  - Repeat steps obey the same wrap and strobe rules as edge steps.
- Without the macro: no FSM and no timer. Only edge steps, as above.

Decomposition:
- Package pulse_counter_pkg holds:
  - FSM state encoding (3-bit localparams).
  - ms_to_cycles constant function.
  - Width helper for the timer, $clog2 of HOLD_CYC.
- Sub-module edge_detect_rise (clk, rst, d, rise) is instantiated twice.
- The counter and FSM stay in the top module.

Test Plan (bench uses CLK_FREQ_HZ=1000, HOLD_MS=5, REPEAT_MS=2, WIDTH=4, MAX_VALUE=9):
- After reset, 3 separate inc_in pulses of 3 cycles each -> count 1,2,3 each 1 cycle after the rise; step_up high exactly 3 cycles total.
- count=9, one inc pulse -> count=0, ovf=1 and step_up=1 for one cycle. Then one dec pulse -> count=9, unf=1.
- inc_in and dec_in rise in the same cycle -> count unchanged, no strobes.
- count=5, inc_in rises coincident with clr=1 -> count=0, no strobes. Holding inc_in afterwards produces no step until it falls and rises again.
- rst asserted asynchronously mid-count (count=7, and under the macro mid-RPT_INC) -> count=0 and strobes 0 immediately. FSM is IDLE after release.
- Macro on: inc_in held 12 cycles from count=0 -> steps at cycle 1 (edge), cycle 6 (hold expiry), then cycles 8, 10, 12 -> count=5. Releasing inc_in stops further steps.
